sipo_deframer: RTL and testbench

Serial-to-parallel receiver. It consumes a framed serial bit stream, such as the one produced by the team's parallel-in/serial-out shifter, and reassembles WIDTH-bit words, LSB first. Each frame is checked for parity and presented on a registered valid/ready output port. It sits directly downstream of the serializer, on the receive side of the serial link.

---
 rtl/sipo_deframer.sv | 131 +++++++++++++
 tb/tb_sipo_deframer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deframer.sv
// sipo_deframer
// Serial-to-parallel receiver. Consumes a framed serial stream
// (start bit '1', WIDTH data bits LSB first, optional even-parity bit)
// and presents each assembled word on a registered valid/ready port.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sin        serial data bit
//   sin_valid  qualifies sin; bits are sampled only when high
//   dout       assembled word (registered)
//   dout_valid dout holds an unconsumed word
//   dout_ready consumer accepts dout on dout_valid & dout_ready
//   dout_perr  parity error flag for the word on dout (0 when PARITY_EN=0)
//   busy       receive FSM is mid-frame
//   ovf        sticky: a completed word was dropped (output full)
//   ovf_clr    synchronous clear of ovf (a simultaneous drop wins)
module sipo_deframer #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_perr,
    output logic             busy,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;

    logic             complete;
    logic [WIDTH-1:0] word;
    logic             word_perr;
    logic             accept;

    // New bits enter at the MSB and shift right, so the first data bit
    // lands in bit 0 once WIDTH bits have been received.
    assign sr_next = {sin, sr[WIDTH-1:1]};

    // The completing edge is the one sampling the last frame bit; the word
    // is taken straight from the combinational path so it registers on
    // that same edge.
    always_comb begin
        complete  = 1'b0;
        word      = sr_next;
        word_perr = 1'b0;
        if (sin_valid) begin
            case (state)
                DATA: begin
                    if (cnt == LAST && !PARITY_EN)
                        complete = 1'b1;
                end
                PARITY: begin
                    complete  = 1'b1;
                    word      = sr;
                    word_perr = (^sr) ^ sin;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else if (sin_valid) begin
            case (state)
                IDLE: begin
                    if (sin == 1'b1) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    sr  <= sr_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST)
                        state <= PARITY_EN ? PARITY : IDLE;
                end
                PARITY: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output register is free when empty or being consumed this edge.
    assign accept = !dout_valid || dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_perr  <= 1'b0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (complete && accept) begin
                dout       <= word;
                dout_perr  <= word_perr;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (complete && !accept)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_deframer.sv
// tb_sipo_deframer
// Self-checking bench for sipo_deframer (WIDTH=4, PARITY_EN=1).
// Expected words are pushed to a scoreboard queue when a frame is driven
// and popped when the DUT presents the word.
module tb_sipo_deframer;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_perr;
    logic       busy;
    logic       ovf;
    logic       ovf_clr;

    typedef struct {
        logic [3:0] data;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks;
    int   n_fail;

    sipo_deframer #(
        .WIDTH    (4),
        .PARITY_EN(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_perr (dout_perr),
        .busy      (busy),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one frame starting at a negedge; returns at the negedge right
    // after the edge that sampled the final (parity) bit.
    task automatic send_frame(input logic [3:0] data, input logic bad_par,
                              input int gaps, input bit expect_load,
                              input bit ready_last);
        logic [5:0] bits;
        bits = {(^data) ^ bad_par, data, 1'b1};
        if (expect_load) begin
            e.data = data;
            e.perr = bad_par;
            sb.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 5 && ready_last) dout_ready = 1'b1;
            sin       = bits[i];
            sin_valid = 1'b1;
            @(negedge clk);
            sin_valid = 1'b0;
            if (i == 5 && ready_last) dout_ready = 1'b0;
            if (i < 5 && gaps > 0) begin
                for (int g = 0; g < gaps; g++) begin
                    @(negedge clk);
                    n_checks++;
                    if (busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL busy_gap bit%0d gap%0d: got %b expected 1", i, g, busy);
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if (dout !== 4'h0 || dout_valid !== 1'b0 || dout_perr !== 1'b0 ||
            busy !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got dout=%h v=%b perr=%b busy=%b ovf=%b expected all 0",
                     dout, dout_valid, dout_perr, busy, ovf);
        end
    endtask

    task automatic test_basic;
        send_frame(4'hD, 1'b0, 0, 1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== e.data || dout_perr !== e.perr) begin
            n_fail++;
            $display("FAIL basic_word: got v=%b dout=%h perr=%b expected v=1 dout=%h perr=%b",
                     dout_valid, dout, dout_perr, e.data, e.perr);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_idle: got %b expected 0", busy);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_handshake: got v=%b expected 0", dout_valid);
        end
    endtask

    task automatic test_bad_parity;
        send_frame(4'hD, 1'b1, 0, 1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== e.data || dout_perr !== e.perr) begin
            n_fail++;
            $display("FAIL bad_parity: got v=%b dout=%h perr=%b expected v=1 dout=%h perr=%b",
                     dout_valid, dout, dout_perr, e.data, e.perr);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    task automatic test_gaps;
        send_frame(4'h6, 1'b0, 3, 1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== e.data || dout_perr !== e.perr) begin
            n_fail++;
            $display("FAIL gaps_word: got v=%b dout=%h perr=%b expected v=1 dout=%h perr=%b",
                     dout_valid, dout, dout_perr, e.data, e.perr);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    task automatic test_overflow;
        send_frame(4'hD, 1'b0, 0, 1'b1, 1'b0);
        send_frame(4'h6, 1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== e.data || dout_perr !== e.perr) begin
            n_fail++;
            $display("FAIL ovf_hold: got v=%b dout=%h perr=%b expected v=1 dout=%h perr=%b",
                     dout_valid, dout, dout_perr, e.data, e.perr);
        end
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got %b expected 1", ovf);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: got %b expected 0", ovf);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_handshake: got v=%b expected 0", dout_valid);
        end
    endtask

    task automatic test_back_to_back;
        send_frame(4'hD, 1'b0, 0, 1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== e.data) begin
            n_fail++;
            $display("FAIL b2b_first: got v=%b dout=%h expected v=1 dout=%h",
                     dout_valid, dout, e.data);
        end
        send_frame(4'h6, 1'b0, 0, 1'b1, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== e.data || dout_perr !== e.perr) begin
            n_fail++;
            $display("FAIL b2b_reload: got v=%b dout=%h perr=%b expected v=1 dout=%h perr=%b",
                     dout_valid, dout, dout_perr, e.data, e.perr);
        end
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_ovf: got %b expected 0", ovf);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [2:0] part;
        // Park a word in the output register so the async clear is visible.
        send_frame(4'hD, 1'b0, 0, 1'b1, 1'b0);
        void'(sb.pop_front());
        part = 3'b011;  // start, data 1, data 0
        for (int i = 0; i < 3; i++) begin
            sin       = part[i];
            sin_valid = 1'b1;
            @(negedge clk);
        end
        sin_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0 || dout !== 4'h0 ||
            dout_perr !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b v=%b dout=%h perr=%b ovf=%b expected all 0",
                     busy, dout_valid, dout, dout_perr, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sin       = 1'b0;
            sin_valid = 1'b1;
            @(negedge clk);
        end
        sin_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_zeros: got busy=%b v=%b expected 0 0", busy, dout_valid);
        end
        send_frame(4'h9, 1'b0, 0, 1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== e.data || dout_perr !== e.perr) begin
            n_fail++;
            $display("FAIL post_reset_word: got v=%b dout=%h perr=%b expected v=1 dout=%h perr=%b",
                     dout_valid, dout, dout_perr, e.data, e.perr);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        dout_ready = 1'b0;
        ovf_clr    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_basic;
        test_bad_parity;
        test_gaps;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
